// File: rtl/br32_pkg.sv
// ============================================================================
// Module      : br32_pkg
// Description : Shared br32 constants and enums used by the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package br32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Load access size as carried from MEM; encoding 3 is reserved and behaves as a word
  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_e;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_stage_if.sv
// ============================================================================
// Module      : wb_stage_if
// Description : MEM handshake, data-bus read response and register-file write
//               port of the br32 writeback stage. The instret counter port is
//               present only when WB_INSTRET_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_stage_if;
  import br32_pkg::*;

  // MEM -> WB
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_w_rd;
  logic [REG_AW-1:0] mem_rd;
  logic [XLEN-1:0]   mem_result;
  logic              mem_is_load;
  logic [1:0]        mem_ld_size;
  logic              mem_ld_signed;
  logic [1:0]        mem_addr_lo;
  // Data bus read response
  logic              dbus_rvalid;
  logic [XLEN-1:0]   dbus_rdata;
  // Register-file write port
  logic              w_rd;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   rd_val;
  logic              stray_rvalid;
`ifdef WB_INSTRET_EN
  logic [63:0]       instret;
`endif

  // Producer side: MEM stage, data bus, and whoever observes the write port
  modport master (
    output mem_valid, mem_w_rd, mem_rd, mem_result, mem_is_load,
           mem_ld_size, mem_ld_signed, mem_addr_lo, dbus_rvalid, dbus_rdata,
    input  mem_ready, w_rd, rd, rd_val, stray_rvalid
`ifdef WB_INSTRET_EN
    , input instret
`endif
  );

  // The writeback stage itself
  modport slave (
    input  mem_valid, mem_w_rd, mem_rd, mem_result, mem_is_load,
           mem_ld_size, mem_ld_signed, mem_addr_lo, dbus_rvalid, dbus_rdata,
    output mem_ready, w_rd, rd, rd_val, stray_rvalid
`ifdef WB_INSTRET_EN
    , output instret
`endif
  );

endinterface

`default_nettype wire

// File: rtl/wb_load_align.sv
// ============================================================================
// Module      : wb_load_align
// Description : Selects the addressed byte/half lane of a word-aligned load
//               response and sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_load_align
  import br32_pkg::*;
(
  input  wire logic [XLEN-1:0] rdata,
  input  wire logic [1:0]      size,
  input  wire logic            ld_signed,
  input  wire logic [1:0]      addr_lo,
  output logic      [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection followed by extension; reserved size falls through to word
  always_comb begin
    byte_v = rdata[8*addr_lo +: 8];
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    if (size == LD_B) begin
      result = {{24{ld_signed & byte_v[7]}}, byte_v};
    end else if (size == LD_H) begin
      result = {{16{ld_signed & half_v[15]}}, half_v};
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ============================================================================
// Module      : wb_stage
// Description : br32 writeback stage. Accepts one instruction per cycle from
//               MEM, holds loads until the data-bus response arrives, and
//               issues a registered one-cycle register-file write pulse.
//               Optional macro WB_INSTRET_EN adds a 64-bit retired counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_stage
  import br32_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  wb_stage_if.slave bus
);

  wb_state_e         state;
  wb_state_e         next_state;
  logic              mem_ready;
  logic              accept;
  logic              load_done;
  logic [XLEN-1:0]   aligned;

  // Load context captured at accept time; MEM is free to move on afterwards
  logic              ld_w_rd;
  logic [REG_AW-1:0] ld_rd;
  logic [1:0]        ld_size;
  logic              ld_signed;
  logic [1:0]        ld_addr_lo;

  logic              w_rd;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   rd_val;
  logic              stray_rvalid;

  assign accept    = bus.mem_valid & mem_ready;
  assign load_done = (state == WAIT_LOAD) & bus.dbus_rvalid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and ready: a load parks the stage until its response arrives
  always_comb begin
    next_state = state;
    mem_ready  = 1'b0;
    case (state)
      IDLE: begin
        mem_ready = 1'b1;
        if (bus.mem_valid && bus.mem_is_load) begin
          next_state = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (bus.dbus_rvalid) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  wb_load_align u_align (
    .rdata     (bus.dbus_rdata),
    .size      (ld_size),
    .ld_signed (ld_signed),
    .addr_lo   (ld_addr_lo),
    .result    (aligned)
  );

  // Capture load context on load accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_w_rd    <= 1'b0;
      ld_rd      <= '0;
      ld_size    <= 2'd0;
      ld_signed  <= 1'b0;
      ld_addr_lo <= 2'd0;
    end else if (accept && bus.mem_is_load) begin
      ld_w_rd    <= bus.mem_w_rd;
      ld_rd      <= bus.mem_rd;
      ld_size    <= bus.mem_ld_size;
      ld_signed  <= bus.mem_ld_signed;
      ld_addr_lo <= bus.mem_addr_lo;
    end
  end

  // Write port: pulse on completion, rd/rd_val hold otherwise; x0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_rd         <= 1'b0;
      rd           <= '0;
      rd_val       <= '0;
      stray_rvalid <= 1'b0;
    end else begin
      w_rd         <= 1'b0;
      stray_rvalid <= (state == IDLE) & bus.dbus_rvalid;
      if (accept && !bus.mem_is_load) begin
        w_rd   <= bus.mem_w_rd & (bus.mem_rd != '0);
        rd     <= bus.mem_rd;
        rd_val <= bus.mem_result;
      end else if (load_done) begin
        w_rd   <= ld_w_rd & (ld_rd != '0);
        rd     <= ld_rd;
        rd_val <= aligned;
      end
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret;

  // Count every retired instruction, whether or not it writes a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if ((accept && !bus.mem_is_load) || load_done) begin
      instret <= instret + 64'd1;
    end
  end

  assign bus.instret = instret;
`endif

  assign bus.mem_ready    = mem_ready;
  assign bus.w_rd         = w_rd;
  assign bus.rd           = rd;
  assign bus.rd_val       = rd_val;
  assign bus.stray_rvalid = stray_rvalid;

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the br32 pipeline. Sits between the memory stage and the register file write port.
- Accepts one instruction per cycle from MEM. For loads, waits for the data-bus read response, then extracts and sign/zero-extends the data.
- Drives the register file write port (w_rd, rd, rd_val) with a registered, single-cycle write pulse.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mem_valid  in  1  MEM stage presents an instruction
- mem_ready  out  1  WB can accept this cycle
- mem_w_rd  in  1  instruction writes rd
- mem_rd  in  5  destination register
- mem_result  in  32  ALU/CSR result for non-loads
- mem_is_load  in  1  instruction is a load
- mem_ld_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- mem_ld_signed  in  1  sign-extend load
- mem_addr_lo  in  2  load address bits [1:0]
- dbus_rvalid  in  1  load data valid
- dbus_rdata  in  32  load data, word-aligned lanes
- w_rd  out  1  register file write enable
- rd  out  5  register file write index
- rd_val  out  32  register file write data
- stray_rvalid  out  1  pulse: rvalid received while no load is outstanding

Behaviour:
- Reset values: state=IDLE, w_rd=0, rd=0, rd_val=0, stray_rvalid=0. mem_ready=1 after reset.
- States:
  - IDLE: nothing held.
  - WAIT_LOAD: load accepted, data outstanding.
- mem_ready is 1 in IDLE and 0 in WAIT_LOAD (combinational from state).
- Accept = mem_valid & mem_ready.
- Non-load accept in IDLE: next cycle w_rd = mem_w_rd & (mem_rd != 0), rd = mem_rd, rd_val = mem_result. Latency 1. Back-to-back non-loads sustain 1 per cycle.
- Load accept: latch rd, w_rd, size, signed, addr_lo; go to WAIT_LOAD. w_rd is 0 the next cycle.
- dbus_rvalid is sampled only in WAIT_LOAD, in the same cycle it is asserted. The earliest useful rvalid is the cycle after accept.
- On rvalid in WAIT_LOAD: next cycle w_rd = latched w_rd & (rd != 0), rd_val = extracted data, state returns to IDLE. A new instruction is accepted in the cycle after rvalid, never in the same cycle.
- Load extraction:
  - byte: lane = addr_lo selects bits [8*addr_lo +: 8].
  - half: lane = addr_lo[1] selects bits [16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - word: full 32 bits; addr_lo is ignored.
  - Extension: sign-extend when signed=1, zero-extend otherwise.
- rd == 0: w_rd is never asserted. rd and rd_val still update.
- w_rd is a one-cycle pulse per instruction. It is 0 on any cycle with no completing instruction; rd and rd_val hold their last values.
- rvalid in IDLE: ignored for writeback; stray_rvalid pulses high the next cycle for one cycle.
- mem_valid while in WAIT_LOAD: not accepted. MEM must hold its inputs stable until mem_ready.
- Reset mid-load: returns to IDLE immediately. An rvalid arriving after reset is treated as stray.

Optional Feature:
- Macro: WB_INSTRET_EN.
- When defined:
  - Adds output instret (64 bits), reset to 0.
  - Increments by 1 on every cycle a non-load is accepted or a load completes (rvalid in WAIT_LOAD), regardless of w_rd or rd value.
  - Wraps modulo 2^64.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package br32_pkg:
  - ld_size_e enum (LD_B=0, LD_H=1, LD_W=2).
  - XLEN and REG_AW constants.
  - wb_state_e (IDLE, WAIT_LOAD).
- One sub-module: wb_load_align. Purely combinational: inputs rdata, size, signed, addr_lo; output the 32-bit extended value. Instantiated once.

Test Plan:
- Non-load, rd=5, result=0x12345678 -> next cycle w_rd=1, rd=5, rd_val=0x12345678; following cycle w_rd=0.
- Signed byte load, addr_lo=3, rdata=0x80FF_0011, rvalid 3 cycles after accept -> mem_ready=0 for those 3 cycles; then w_rd=1, rd_val=0xFFFFFF80.
- Unsigned half load, addr_lo=2, rdata=0xBEEF_1234 -> rd_val=0x0000BEEF. Same load with signed=1 -> rd_val=0xFFFFBEEF.
- Non-load with rd=0, result=0xDEADBEEF -> w_rd stays 0 for all cycles.
- rvalid in IDLE -> stray_rvalid=1 for exactly one cycle, w_rd=0. Reset asserted during WAIT_LOAD, then rvalid -> state IDLE, stray_rvalid pulses, no write.
- Three back-to-back non-loads (rd=1,2,3), then a load -> w_rd=1 for 3 consecutive cycles with matching rd; with WB_INSTRET_EN, instret=4 after the load completes.
